pixel32_pack128: RTL and testbench

- Downstream stage of the 24-to-32-bit RGB expander. Consumes the 32-bit ARGB pixel stream under video timing (vs/de).
- Packs consecutive pixels into OUT_WIDTH-bit words for the frame-buffer write path (FDMA/VDMA write FIFO).
- The input side cannot stall. The output side uses a valid/ready handshake backed by a 2-entry buffer, with a sticky overflow flag.

---
 rtl/pixel_pack_pkg.sv | 21 ++
 rtl/pixel32_pack128_fifo.sv | 64 ++++++
 rtl/pixel32_pack128.sv | 146 ++++++++++++++
 tb/tb_pixel32_pack128.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pack_pkg.sv
// Shared constants and elaboration helpers for the 32-bit pixel packer.
package pixel_pack_pkg;

   localparam int unsigned PIX_W = 32;

   // Number of 32-bit pixels carried by one output word.
   function automatic int unsigned pix_per_word(input int unsigned out_width);
      return out_width / PIX_W;
   endfunction

   // Ceiling log2 with a fixed loop bound; used to size the lane counter.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) r = 32'(i) + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pixel32_pack128_fifo.sv
// pack_fifo2: 2-entry first-word-fall-through buffer for {sof, data} words.
// The head entry drives rdata directly, so the consumer sees registered data.
module pack_fifo2
   import pixel_pack_pkg::*;
#(
   parameter int unsigned W = 129
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] tail;
   logic [W-1:0] head_n;
   logic [W-1:0] tail_n;
   logic         full_n;
   logic         empty_n;

   // Next-state: apply the pop first so a push into a full buffer can reuse the freed slot.
   always_comb begin
      head_n  = rdata;
      tail_n  = tail;
      full_n  = full;
      empty_n = empty;
      if (pop && !empty) begin
         if (full) begin
            head_n = tail;
            full_n = 1'b0;
         end else begin
            empty_n = 1'b1;
         end
      end
      if (push) begin
         if (empty_n) begin
            head_n  = wdata;
            empty_n = 1'b0;
         end else if (!full_n) begin
            tail_n = wdata;
            full_n = 1'b1;
         end
      end
   end

   // Storage and occupancy flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
         tail  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         rdata <= head_n;
         tail  <= tail_n;
         full  <= full_n;
         empty <= empty_n;
      end
   end

endmodule

// File: rtl/pixel32_pack128.sv
// pixel32_pack128: packs a non-stallable 32-bit ARGB pixel stream into OUT_WIDTH-bit
// words (first pixel at the LSBs) behind a 2-entry valid/ready buffer.
// Optional build macro PIXEL_PACK_LINE_FLUSH_EN: flush a partial word one cycle after
// each de_i falling edge instead of carrying it into the next line.
module pixel32_pack128
   import pixel_pack_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = 128,
   parameter bit          VS_POL    = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 vs_i,
   input  logic                 de_i,
   input  logic [PIX_W-1:0]     rgb32_i,
   output logic [OUT_WIDTH-1:0] out_data_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 out_sof_o,
   output logic                 ovf_o
);

   localparam int unsigned PPW    = pix_per_word(OUT_WIDTH);
   localparam int unsigned CNT_W  = clog2(PPW);
   localparam int unsigned FIFO_W = OUT_WIDTH + 1;

   logic                 vs_q;
   logic [CNT_W-1:0]     cnt;
   logic [OUT_WIDTH-1:0] acc;
   logic                 sof_pending;

   logic                 frame_start_c;
   logic                 flush_push_c;
   logic [CNT_W-1:0]     cnt_base;
   logic [OUT_WIDTH-1:0] acc_base;
   logic [OUT_WIDTH-1:0] acc_wr;
   logic                 word_done_c;
   logic                 push_c;
   logic [OUT_WIDTH-1:0] push_data_c;
   logic                 push_sof_c;
   logic                 pop_c;
   logic                 accept_c;
   logic                 drop_c;
   logic [CNT_W-1:0]     cnt_n;
   logic [OUT_WIDTH-1:0] acc_n;
   logic                 sof_pending_n;
   logic                 ovf_n;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [FIFO_W-1:0]    fifo_rdata;

   assign frame_start_c = (vs_i == VS_POL) && (vs_q != VS_POL);

`ifdef PIXEL_PACK_LINE_FLUSH_EN
   logic de_q;
   logic flush_q;

   // Track de_i so the cycle after a falling edge can flush the partial word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         de_q    <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         de_q    <= de_i;
         flush_q <= de_q & ~de_i;
      end
   end

   // A frame start discards the partial word, so it wins over a flush.
   assign flush_push_c = flush_q && (cnt != '0) && !frame_start_c;
`else
   assign flush_push_c = 1'b0;
`endif

   // Lane packing: a frame start or flush clears first, then the pixel lands in the cleared accumulator.
   always_comb begin
      cnt_base = cnt;
      acc_base = acc;
      if (frame_start_c || flush_push_c) begin
         cnt_base = '0;
         acc_base = '0;
      end
      acc_wr = acc_base;
      if (de_i) acc_wr[int'(cnt_base) * PIX_W +: PIX_W] = rgb32_i;
      word_done_c = de_i && (cnt_base == CNT_W'(PPW - 1));
      push_c      = word_done_c || flush_push_c;
      push_data_c = flush_push_c ? acc : acc_wr;
      push_sof_c  = sof_pending || frame_start_c;

      cnt_n = cnt_base;
      acc_n = acc_wr;
      if (word_done_c) begin
         cnt_n = '0;
         acc_n = '0;
      end else if (de_i) begin
         cnt_n = cnt_base + CNT_W'(1);
      end
   end

   // Handshake, drop detection and frame-scoped flags.
   always_comb begin
      pop_c    = !fifo_empty && out_ready_i;
      accept_c = !fifo_full || pop_c;
      drop_c   = push_c && !accept_c;

      sof_pending_n = sof_pending || frame_start_c;
      if (push_c && accept_c) sof_pending_n = 1'b0;

      ovf_n = ovf_o || drop_c;
      if (frame_start_c) ovf_n = 1'b0;
   end

   // Packer state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vs_q        <= ~VS_POL;
         cnt         <= '0;
         acc         <= '0;
         sof_pending <= 1'b0;
         ovf_o       <= 1'b0;
      end else begin
         vs_q        <= vs_i;
         cnt         <= cnt_n;
         acc         <= acc_n;
         sof_pending <= sof_pending_n;
         ovf_o       <= ovf_n;
      end
   end

   pack_fifo2 #(
      .W(FIFO_W)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push_c),
      .wdata ({push_sof_c, push_data_c}),
      .pop   (pop_c),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {out_sof_o, out_data_o} = fifo_rdata;
   assign out_valid_o             = ~fifo_empty;

endmodule

// File: tb/tb_pixel32_pack128.sv
// Self-checking bench for pixel32_pack128 (OUT_WIDTH=128, VS_POL=1).
module tb_pixel32_pack128;

   logic         clk_i;
   logic         rst_i;
   logic         vs_i;
   logic         de_i;
   logic [31:0]  rgb32_i;
   logic [127:0] out_data_o;
   logic         out_valid_o;
   logic         out_ready_i;
   logic         out_sof_o;
   logic         ovf_o;

   int passed;
   int total;
   logic [128:0] sb[$];

   typedef struct {
      logic        vs;
      logic        de;
      logic [31:0] pix;
      logic        ready;
      logic        exp_valid;
      logic        exp_sof;
      logic        exp_ovf;
   } vec_t;

   vec_t t1[10];

   pixel32_pack128 #(
      .OUT_WIDTH(128),
      .VS_POL   (1'b1)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .vs_i       (vs_i),
      .de_i       (de_i),
      .rgb32_i    (rgb32_i),
      .out_data_o (out_data_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_sof_o  (out_sof_o),
      .ovf_o      (ovf_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [128:0] word(input logic sof, input logic [31:0] p3, input logic [31:0] p2,
                                         input logic [31:0] p1, input logic [31:0] p0);
      return {sof, p3, p2, p1, p0};
   endfunction

   // One clock: score any transfer happening at the coming edge, then step past it.
   task automatic tick();
      logic [128:0] exp;
      @(negedge clk_i);
      if (!rst_i && out_valid_o && out_ready_i) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL xfer_unexpected: got %h expected no word", {out_sof_o, out_data_o});
         end else begin
            exp = sb.pop_front();
            check("xfer", {out_sof_o, out_data_o}, exp);
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic vs, input logic de, input logic [31:0] pix, input logic rdy);
      vs_i        = vs;
      de_i        = de;
      rgb32_i     = pix;
      out_ready_i = rdy;
      tick();
   endtask

   initial begin
      passed      = 0;
      total       = 0;
      rst_i       = 1'b1;
      vs_i        = 1'b0;
      de_i        = 1'b0;
      rgb32_i     = '0;
      out_ready_i = 1'b0;
      #1;
      check("rst_valid", 129'(out_valid_o), 129'(0));
      check("rst_sof",   129'(out_sof_o),   129'(0));
      check("rst_ovf",   129'(ovf_o),       129'(0));
      check("rst_data",  129'(out_data_o),  129'(0));
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Test 1: first frame, four pixels per word, sof on the first word only.
      t1[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
      t1[1] = '{1'b1, 1'b1, 32'hFF000001,  1'b1, 1'b0, 1'b0, 1'b0};
      t1[2] = '{1'b1, 1'b1, 32'hFF000002,  1'b1, 1'b0, 1'b0, 1'b0};
      t1[3] = '{1'b1, 1'b1, 32'hFF000003,  1'b1, 1'b0, 1'b0, 1'b0};
      t1[4] = '{1'b1, 1'b1, 32'hFF000004,  1'b1, 1'b1, 1'b1, 1'b0};
      t1[5] = '{1'b1, 1'b1, 32'hFF000005,  1'b1, 1'b0, 1'b0, 1'b0};
      t1[6] = '{1'b1, 1'b1, 32'hFF000006,  1'b1, 1'b0, 1'b0, 1'b0};
      t1[7] = '{1'b1, 1'b1, 32'hFF000007,  1'b1, 1'b0, 1'b0, 1'b0};
      t1[8] = '{1'b1, 1'b1, 32'hFF000008,  1'b1, 1'b1, 1'b0, 1'b0};
      t1[9] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
      sb.push_back(word(1'b1, 32'hFF000004, 32'hFF000003, 32'hFF000002, 32'hFF000001));
      sb.push_back(word(1'b0, 32'hFF000008, 32'hFF000007, 32'hFF000006, 32'hFF000005));
      for (int i = 0; i < 10; i++) begin
         drive(t1[i].vs, t1[i].de, t1[i].pix, t1[i].ready);
         check($sformatf("t1_valid[%0d]", i), 129'(out_valid_o), 129'(t1[i].exp_valid));
         check($sformatf("t1_ovf[%0d]", i),   129'(ovf_o),       129'(t1[i].exp_ovf));
         if (t1[i].exp_valid) check($sformatf("t1_sof[%0d]", i), 129'(out_sof_o), 129'(t1[i].exp_sof));
      end

      // Test 2: stalled consumer, third word dropped, words held in order, ovf cleared by frame start.
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 1; i <= 12; i++) drive(1'b1, 1'b1, 32'h02000000 + 32'(i), 1'b0);
      check("t2_ovf_set", 129'(ovf_o), 129'(1));
      check("t2_hold", {out_sof_o, out_data_o},
            word(1'b1, 32'h02000004, 32'h02000003, 32'h02000002, 32'h02000001));
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      check("t2_hold2", {out_sof_o, out_data_o},
            word(1'b1, 32'h02000004, 32'h02000003, 32'h02000002, 32'h02000001));
      sb.push_back(word(1'b1, 32'h02000004, 32'h02000003, 32'h02000002, 32'h02000001));
      sb.push_back(word(1'b0, 32'h02000008, 32'h02000007, 32'h02000006, 32'h02000005));
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      check("t2_drained", 129'(out_valid_o), 129'(0));
      check("t2_ovf_sticky", 129'(ovf_o), 129'(1));
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      check("t2_ovf_clear", 129'(ovf_o), 129'(0));

      // Test 3: line boundary handling of a partial word.
      sb.push_back(word(1'b1, 32'h03000004, 32'h03000003, 32'h03000002, 32'h03000001));
`ifdef PIXEL_PACK_LINE_FLUSH_EN
      sb.push_back(word(1'b0, 32'h0, 32'h0, 32'h03000006, 32'h03000005));
      sb.push_back(word(1'b0, 32'h03100004, 32'h03100003, 32'h03100002, 32'h03100001));
`else
      sb.push_back(word(1'b0, 32'h03100002, 32'h03100001, 32'h03000006, 32'h03000005));
`endif
      for (int i = 1; i <= 6; i++) drive(1'b1, 1'b1, 32'h03000000 + 32'(i), 1'b1);
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      check("t3_fall_cycle", 129'(out_valid_o), 129'(0));
      drive(1'b1, 1'b1, 32'h03100001, 1'b1);
`ifdef PIXEL_PACK_LINE_FLUSH_EN
      check("t3_flush_valid", 129'(out_valid_o), 129'(1));
`else
      check("t3_no_flush", 129'(out_valid_o), 129'(0));
`endif
      for (int i = 2; i <= 4; i++) drive(1'b1, 1'b1, 32'h03100000 + 32'(i), 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);

      // Test 4: frame start coincident with a pixel discards the partial word.
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b1, 32'h04000001, 1'b1);
      drive(1'b0, 1'b1, 32'h04000002, 1'b1);
      sb.push_back(word(1'b1, 32'h04000013, 32'h04000012, 32'h04000011, 32'h040000AA));
      drive(1'b1, 1'b1, 32'h040000AA, 1'b1);
      for (int i = 1; i <= 3; i++) drive(1'b1, 1'b1, 32'h04000010 + 32'(i), 1'b1);
      check("t4_valid", 129'(out_valid_o), 129'(1));
      check("t4_lane0", 129'(out_data_o[31:0]), 129'(32'h040000AA));
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1);

      // Test 5: asynchronous reset mid-word with buffered words and ovf set.
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 1; i <= 14; i++) drive(1'b1, 1'b1, 32'h05000000 + 32'(i), 1'b0);
      check("t5_pre_valid", 129'(out_valid_o), 129'(1));
      check("t5_pre_ovf", 129'(ovf_o), 129'(1));
      vs_i  = 1'b0;
      de_i  = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      check("t5_rst_valid", 129'(out_valid_o), 129'(0));
      check("t5_rst_sof",   129'(out_sof_o),   129'(0));
      check("t5_rst_ovf",   129'(ovf_o),       129'(0));
      check("t5_rst_data",  129'(out_data_o),  129'(0));
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      sb.push_back(word(1'b0, 32'h05100004, 32'h05100003, 32'h05100002, 32'h05100001));
      for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 32'h05100000 + 32'(i), 1'b1);
      check("t5_post_valid", 129'(out_valid_o), 129'(1));
      drive(1'b0, 1'b0, 32'h0, 1'b1);

      // Test 6: full buffer, pop and push on the same edge, no drop.
      sb.push_back(word(1'b1, 32'h06000004, 32'h06000003, 32'h06000002, 32'h06000001));
      sb.push_back(word(1'b0, 32'h06000008, 32'h06000007, 32'h06000006, 32'h06000005));
      sb.push_back(word(1'b0, 32'h0600000C, 32'h0600000B, 32'h0600000A, 32'h06000009));
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 1; i <= 11; i++) drive(1'b1, 1'b1, 32'h06000000 + 32'(i), 1'b0);
      drive(1'b1, 1'b1, 32'h0600000C, 1'b1);
      check("t6_ovf", 129'(ovf_o), 129'(0));
      check("t6_valid", 129'(out_valid_o), 129'(1));
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
      check("t6_drained", 129'(out_valid_o), 129'(0));
      check("t6_ovf_end", 129'(ovf_o), 129'(0));

      check("sb_empty", 129'(sb.size()), 129'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
